bird_column: RTL

- Parametrised successor to the single-cell bird light: one block owns the bird's whole LED column instead of one cell per row.
- Tracks the bird's row and drives a one-hot light vector for the column.
- Applies flap (up) and timed gravity (down), detects ground hits and pipe collisions, and reports a crash to the game controller.
- Sits between the flap-key edge detector and the LED matrix driver.

---
 rtl/bird_column.sv | 96 +++++++++
 1 files changed

// File: rtl/bird_column.sv
// bird_column: the bird's whole LED column.
// Keeps the bird's row. Applies flap lift and timed gravity.
// Detects ground hits and pipe collisions and reports a crash.
module bird_column #(
   parameter int ROWS       = 8,
   parameter int START_ROW  = 4,
   parameter int FALL_TICKS = 16,
   parameter int FLAP_ROWS  = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in,
   input  logic                    restart,
   input  logic                    pause,
   input  logic [ROWS-1:0]         wall,
   output logic [ROWS-1:0]         lights,
   output logic [$clog2(ROWS)-1:0] pos,
   output logic                    flying,
   output logic                    crashed
);

   localparam int PW = $clog2(ROWS);
   localparam int CW = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FLYING = 2'd1,
      DEAD   = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] fall_cnt;
   logic [PW-1:0] flap_pos;
   logic          hit;
   logic          tick;

   // Flap target: FLAP_ROWS above the current row, saturating at the ceiling.
   always_comb begin
      // NOTE: give every combinational output a default first so no path leaves it unassigned (no latch).
      flap_pos = PW'(ROWS - 1);
      if (int'(pos) + FLAP_ROWS < ROWS)
         flap_pos = PW'(int'(pos) + FLAP_ROWS);
   end

   assign hit  = |(wall & lights);
   assign tick = (fall_cnt == CW'(FALL_TICKS - 1));

   // Bird FSM: restart beats pause, and pause beats normal flight logic.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!reset) begin
         state    <= IDLE;
         pos      <= PW'(START_ROW);
         fall_cnt <= '0;
      end else if (restart) begin
         state    <= IDLE;
         pos      <= PW'(START_ROW);
         fall_cnt <= '0;
      end else if (!pause) begin
         case (state)
            IDLE: begin
               if (in) begin
                  state    <= FLYING;
                  pos      <= flap_pos;
                  fall_cnt <= '0;
               end
            end
            FLYING: begin
               if (hit) begin
                  state <= DEAD;
               end else if (in) begin
                  pos      <= flap_pos;
                  fall_cnt <= '0;
               end else if (tick) begin
                  fall_cnt <= '0;
                  if (pos == '0)
                     state <= DEAD;
                  else
                     pos <= pos - 1'b1;
               end else begin
                  fall_cnt <= fall_cnt + 1'b1;
               end
            end
            DEAD: begin
               // Only restart or reset leaves DEAD.
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign lights  = ROWS'(1) << pos;
   assign flying  = (state == FLYING);
   assign crashed = (state == DEAD);

endmodule
